// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (I-cache / D-cache) line arbiter in front of a fixed-latency memory.
// Define ARB_FIXED_PRIO_EN to make ties always go to the D-cache; otherwise ties alternate.
module mem_arbiter #(
   parameter int MEM_LAT = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         ic_req_valid_i,
   input  logic [31:0]  ic_addr_i,
   output logic         ic_resp_valid_o,
   output logic [127:0] ic_rdata_o,
   input  logic         dc_req_valid_i,
   input  logic         dc_rw_i,
   input  logic [31:0]  dc_addr_i,
   input  logic [127:0] dc_wdata_i,
   output logic         dc_resp_valid_o,
   output logic [127:0] dc_rdata_o,
   output logic [31:0]  mem_addr_o,
   output logic [127:0] mem_dataW_o,
   output logic         mem_MemRW_o,
   output logic         mem_req_valid_o,
   input  logic [127:0] mem_dataR_i,
   input  logic         mem_valid_i
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam logic [3:0] LAST = 4'(MEM_LAT - 1);
   state_t state, state_nx;
   logic [3:0] cnt;
   logic gnt_d, pick_d, lat_rw, any_req, done;
   logic [31:0] lat_addr;
   logic [127:0] lat_wdata;
   assign any_req = ic_req_valid_i | dc_req_valid_i;
   assign done = (state == WAIT) && (cnt == LAST) && mem_valid_i;
`ifdef ARB_FIXED_PRIO_EN
   assign pick_d = dc_req_valid_i;
`else
   logic last_d;
   assign pick_d = dc_req_valid_i & (~ic_req_valid_i | ~last_d);
   // remember who was served last so the next tie goes to the other side
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) last_d <= 1'b1;
      else if (state == RESP) last_d <= gnt_d;
   end
`endif
   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = any_req ? ISSUE : IDLE;
         ISSUE:   state_nx = WAIT;
         WAIT:    state_nx = done ? RESP : WAIT;
         default: state_nx = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else state <= state_nx;
   end
   // latch the granted request and run the saturating wait counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gnt_d     <= 1'b0;
         lat_rw    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         cnt       <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            gnt_d     <= pick_d;
            lat_rw    <= pick_d & dc_rw_i;
            lat_addr  <= pick_d ? dc_addr_i : ic_addr_i;
            lat_wdata <= pick_d ? dc_wdata_i : '0;
         end
         if (state == ISSUE) cnt <= '0;
         else if (state == WAIT && cnt != LAST) cnt <= cnt + 4'd1;
      end
   end
   // capture memory read data for the granted requester; writes return zero
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ic_rdata_o <= '0;
         dc_rdata_o <= '0;
      end else if (done) begin
         if (gnt_d) dc_rdata_o <= lat_rw ? '0 : mem_dataR_i;
         else ic_rdata_o <= lat_rw ? '0 : mem_dataR_i;
      end
   end
   assign mem_req_valid_o = state == ISSUE;
   assign mem_MemRW_o     = (state == ISSUE) & lat_rw;
   assign mem_addr_o      = (state == IDLE) ? '0 : lat_addr;
   assign mem_dataW_o     = (state == IDLE) ? '0 : lat_wdata;
   assign ic_resp_valid_o = (state == RESP) & ~gnt_d;
   assign dc_resp_valid_o = (state == RESP) & gnt_d;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: MEM_LAT, 2, memory wait cycles after issue (legal range 1..15).
REQ-002 SHALL have ports (name direction width meaning), clock and reset first:
- clk_i  in  1  sole clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- ic_req_valid_i  in  1  I-cache line-fill request
- ic_addr_i  in  32  I-cache byte address, 16B aligned
- ic_resp_valid_o  out  1  I-cache response pulse
- ic_rdata_o  out  128  I-cache line data
- dc_req_valid_i  in  1  D-cache request
- dc_rw_i  in  1  1=write-back, 0=fill
- dc_addr_i  in  32  D-cache byte address, 16B aligned
- dc_wdata_i  in  128  D-cache write line
- dc_resp_valid_o  out  1  D-cache response pulse
- dc_rdata_o  out  128  D-cache line data
- mem_addr_o  out  32  to memory addr_i
- mem_dataW_o  out  128  to memory dataW_i
- mem_MemRW_o  out  1  to memory MemRW_i
- mem_req_valid_o  out  1  to memory mem_req_valid_i
- mem_dataR_i  in  128  from memory dataR_o (combinational on address)
- mem_valid_i  in  1  from memory Valid_memory2cache_o

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-004 IDLE: if any req_valid high, SHALL grant one requester, latch its addr/rw/wdata into internal registers, go to ISSUE next cycle; else stay IDLE.
REQ-005 I-cache requests SHALL be treated as reads (rw=0).
REQ-006 Tie (both valid in IDLE): SHALL grant requester not granted last; last-grant register resets to D, so I-cache wins the first tie.
REQ-007 ISSUE (exactly 1 cycle): mem_req_valid_o=1, mem_MemRW_o=latched rw; go to WAIT with wait counter cleared.
REQ-008 WAIT: mem_req_valid_o=0, mem_MemRW_o=0; counter increments each cycle; leaves WAIT when counter==MEM_LAT-1 and mem_valid_i=1; if mem_valid_i=0 at that point SHALL hold in WAIT with counter saturated.
REQ-009 On leaving WAIT SHALL register mem_dataR_i into the granted requester's rdata (reads only; writes capture 128'h0) and go to RESP.
REQ-010 RESP (1 cycle): granted requester's resp_valid_o=1, other's 0; update last-grant; return to IDLE.
REQ-011 mem_addr_o and mem_dataW_o SHALL hold latched values from ISSUE through RESP; in IDLE both 0.
REQ-012 Requesters hold req_valid and inputs until resp pulse; arbiter SHALL ignore input changes after latch.
REQ-013 A req_valid deasserted before grant SHALL be dropped silently; req_valid still high in cycle after RESP SHALL be treated as a new request.
REQ-014 Transaction latency, grant cycle to resp pulse: MEM_LAT+2 cycles (no mem_valid stall).
REQ-015 rdata outputs SHALL hold their last captured value until next capture for that requester.
REQ-016 Wait counter SHALL be 4 bits; no wrap permitted.

Reset
REQ-017 rst_ni low SHALL asynchronously force: state IDLE, counter 0, last-grant D, all latched registers 0, every output 0.
REQ-018 Reset mid-transaction SHALL abort it with no resp pulse; mem_req_valid_o and mem_MemRW_o SHALL drop same cycle as reset assertion.
REQ-019 First grant possible on first rising edge after rst_ni deasserts.

Configuration
REQ-020 Macro ARB_FIXED_PRIO_EN defined: ties SHALL always grant D-cache; last-grant register absent.
REQ-021 Macro undefined: round-robin per REQ-006.

Verification
REQ-022 I-cache read addr 0x0000_0800, memory returns 128'hA5A5_..., MEM_LAT=2 -> mem_req_valid_o high 1 cycle, ic_resp_valid_o pulse 4 cycles after grant, ic_rdata_o=128'hA5A5_....
REQ-023 D-cache write addr 0x0000_0810, wdata 128'h1234 -> mem_MemRW_o=1 only in ISSUE cycle, dc_resp_valid_o pulse, dc_rdata_o=0.
REQ-024 Both request continuously from reset -> grant order I,D,I,D (D,D,D,D with ARB_FIXED_PRIO_EN).
REQ-025 mem_valid_i forced 0 for 5 cycles during WAIT -> no resp until mem_valid_i=1, then resp next cycle.
REQ-026 rst_ni asserted in WAIT -> outputs 0 immediately, no resp pulse; new request after release completes normally.
